// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: a single-master, multi-slave bus fabric.
// The master request is decoded against per-slave base/mask pairs. The request
// is latched into registered slave-side outputs, and the selected slave's
// completion is turned into a one-cycle m_ready pulse.
// Optional feature: define SOC_BUS_TIMEOUT_EN to abort an ACCESS that is still
// waiting after TIMEOUT_CYCLES cycles. When the macro is undefined, ACCESS
// waits for s_ready indefinitely.

// Address decode for one slave port.
module soc_bus_fabric_dec_lane #(
   parameter logic [31:0] BASE = 32'h0,
   parameter logic [31:0] MASK = 32'h0
) (
   input  logic [31:0] addr,
   output logic        hit
);
   assign hit = ((addr & MASK) == BASE);
endmodule

module soc_bus_fabric #(
   parameter int NUM_SLAVES = 4,
   parameter logic [NUM_SLAVES*32-1:0] SLV_BASE =
      {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVES*32-1:0] SLV_MASK = {4{32'hF000_0000}},
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       m_req,
   input  logic                       m_we,
   input  logic [31:0]                m_addr,
   input  logic [31:0]                m_wdata,
   input  logic [3:0]                 m_be,
   output logic [31:0]                m_rdata,
   output logic                       m_ready,
   output logic                       m_err,
   output logic [NUM_SLAVES-1:0]      s_sel,
   output logic                       s_we,
   output logic [31:0]                s_addr,
   output logic [31:0]                s_wdata,
   output logic [3:0]                 s_be,
   input  logic [NUM_SLAVES*32-1:0]   s_rdata,
   input  logic [NUM_SLAVES-1:0]      s_ready
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                  state_q, state_d;
   logic [NUM_SLAVES-1:0]   hit;        // raw per-slave decode
   logic [NUM_SLAVES-1:0]   hit_oh;     // lowest-index hit only
   logic [NUM_SLAVES-1:0]   sel_q;      // slave chosen at latch time
   logic [31:0]             rdata_sel;
   logic                    ready_sel;
   logic                    start;
   logic                    tmo_hit;

   // Out-of-range configurations are rejected at elaboration.
   if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255)
   begin : g_bad_cfg
      $error("soc_bus_fabric: NUM_SLAVES or TIMEOUT_CYCLES out of range");
   end

   for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_lane
      soc_bus_fabric_dec_lane #(
         .BASE(SLV_BASE[i*32 +: 32]),
         .MASK(SLV_MASK[i*32 +: 32])
      ) u_lane (
         .addr(m_addr),
         .hit (hit[i])
      );
   end

   // Priority select: overlapping windows resolve to the lowest slave index.
   always_comb begin
      hit_oh = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (hit[i]) begin
            hit_oh    = '0;
            hit_oh[i] = 1'b1;
         end
      end
   end

   // Only the latched slave's ready and read data are observed.
   always_comb begin
      rdata_sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q[i]) rdata_sel = rdata_sel | s_rdata[i*32 +: 32];
      end
   end

   assign ready_sel = |(s_ready & sel_q);
   assign start     = (state_q == IDLE) && m_req;

`ifdef SOC_BUS_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   // Count cycles spent in ACCESS; cleared whenever the FSM is elsewhere.
   always_ff @(posedge clk) begin
      if (reset || state_q != ACCESS) tmo_cnt <= '0;
      else                            tmo_cnt <= tmo_cnt + 8'd1;
   end

   // This fires on the last allowed ACCESS cycle. A ready in the same cycle
   // takes precedence.
   assign tmo_hit = (state_q == ACCESS) && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic: a decode miss skips ACCESS and answers straight away.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (m_req) state_d = (|hit_oh) ? ACCESS : RESP;
         ACCESS:  if (ready_sel || tmo_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: slave select only during ACCESS, ready only during RESP.
   always_comb begin
      s_sel   = '0;
      m_ready = 1'b0;
      case (state_q)
         ACCESS:  s_sel   = sel_q;
         RESP:    m_ready = 1'b1;
         default: ;
      endcase
   end

   // Request latch and response capture. m_rdata and m_err hold between
   // transfers, so only m_ready qualifies them.
   always_ff @(posedge clk) begin
      if (reset) begin
         s_we    <= 1'b0;
         s_addr  <= '0;
         s_wdata <= '0;
         s_be    <= '0;
         sel_q   <= '0;
         m_rdata <= '0;
         m_err   <= 1'b0;
      end else begin
         if (start) begin
            s_we    <= m_we;
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            s_be    <= m_be;
            sel_q   <= hit_oh;
         end
         if (start && !(|hit_oh)) begin
            m_rdata <= '0;
            m_err   <= 1'b1;
         end else if (state_q == ACCESS && ready_sel) begin
            m_rdata <= s_we ? 32'h0 : rdata_sel;
            m_err   <= 1'b0;
         end else if (tmo_hit) begin
            m_rdata <= '0;
            m_err   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Testbench for soc_bus_fabric. It uses a transaction-level reference model:
// decode by rule, then predict the ACCESS length and the response of each
// transfer. Two instances are used: the default map, and an overlapping map.
module tb_soc_bus_fabric;
   localparam int NS  = 4;
   localparam int TMO = 16;
`ifdef SOC_BUS_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic              m_req, m_we;
   logic [31:0]       m_addr, m_wdata;
   logic [3:0]        m_be;
   logic [NS*32-1:0]  s_rdata;
   logic [NS-1:0]     s_ready;

   logic [31:0]       a_rdata, b_rdata, a_addr, b_addr, a_wdata, b_wdata;
   logic              a_ready, b_ready, a_err, b_err, a_we, b_we;
   logic [NS-1:0]     a_sel, b_sel;
   logic [3:0]        a_be, b_be;

   soc_bus_fabric #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(TMO)) u_dut (
      .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_be(m_be), .m_rdata(a_rdata), .m_ready(a_ready),
      .m_err(a_err), .s_sel(a_sel), .s_we(a_we), .s_addr(a_addr),
      .s_wdata(a_wdata), .s_be(a_be), .s_rdata(s_rdata), .s_ready(s_ready));

   soc_bus_fabric #(
      .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TMO),
      .SLV_BASE({32'h3000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000}),
      .SLV_MASK({32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'h0000_0000})
   ) u_ovl (
      .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_be(m_be), .m_rdata(b_rdata), .m_ready(b_ready),
      .m_err(b_err), .s_sel(b_sel), .s_we(b_we), .s_addr(b_addr),
      .s_wdata(b_wdata), .s_be(b_be), .s_rdata(s_rdata), .s_ready(s_ready));

   // Observed view: the instance under test
   bit            use_ovl = 1'b0;
   logic [31:0]   o_rdata, o_addr, o_wdata;
   logic          o_ready, o_err, o_we;
   logic [NS-1:0] o_sel;
   logic [3:0]    o_be;
   assign o_rdata = use_ovl ? b_rdata : a_rdata;
   assign o_ready = use_ovl ? b_ready : a_ready;
   assign o_err   = use_ovl ? b_err   : a_err;
   assign o_sel   = use_ovl ? b_sel   : a_sel;
   assign o_we    = use_ovl ? b_we    : a_we;
   assign o_addr  = use_ovl ? b_addr  : a_addr;
   assign o_wdata = use_ovl ? b_wdata : a_wdata;
   assign o_be    = use_ovl ? b_be    : a_be;

   // Address maps in reference form
   bit [31:0] base_a[NS] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
   bit [31:0] mask_a[NS] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
   bit [31:0] base_b[NS] = '{32'h0000_0000, 32'h0000_0000, 32'h2000_0000, 32'h3000_0000};
   bit [31:0] mask_b[NS] = '{32'h0000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

   int checks = 0;
   int errors = 0;

   function automatic int ref_decode(input logic [31:0] a, input bit ovl);
      for (int i = 0; i < NS; i++) begin
         if (ovl) begin
            if ((a & mask_b[i]) == base_b[i]) return i;
         end else if ((a & mask_a[i]) == base_a[i]) return i;
      end
      return -1;
   endfunction

   task automatic junk_inputs();
      m_req   = 1'($urandom);
      m_we    = 1'($urandom);
      m_addr  = $urandom;
      m_wdata = $urandom;
      m_be    = 4'($urandom);
      s_rdata = {$urandom, $urandom, $urandom, $urandom};
      s_ready = 4'($urandom);
   endtask

   // One transfer, starting in an IDLE cycle. delay = number of ACCESS cycles
   // before the target slave asserts s_ready.
   task automatic do_xfer(input logic [31:0] addr, input logic we,
                          input logic [31:0] wd, input logic [3:0] be,
                          input int delay, input string tag);
      int          idx, resp_cyc;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic [NS-1:0] exp_sel;
      idx = ref_decode(addr, use_ovl);
      exp_rd = 32'h0;
      exp_sel = '0;
      if (idx >= 0) exp_sel[idx] = 1'b1;
      if (idx < 0) begin
         resp_cyc = 1; exp_err = 1'b1;
      end else if (TMO_EN && delay >= TMO) begin
         resp_cyc = TMO + 1; exp_err = 1'b1;
      end else begin
         resp_cyc = delay + 2; exp_err = 1'b0;
      end
      junk_inputs();
      m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wd; m_be = be;
      for (int c = 1; c <= resp_cyc; c++) begin
         @(posedge clk); #1;
         if (c < resp_cyc) begin
            checks++;
            if (o_sel !== exp_sel || o_ready !== 1'b0)
               $display("FAIL %s access c=%0d sel=%b ready=%b exp sel=%b ready=0",
                        tag, c, o_sel, o_ready, exp_sel);
            if (o_sel !== exp_sel || o_ready !== 1'b0) errors++;
            checks++;
            if ({o_we, o_addr, o_wdata, o_be} !== {we, addr, wd, be}) begin
               errors++;
               $display("FAIL %s slave_req c=%0d got %b/%h/%h/%b exp %b/%h/%h/%b",
                        tag, c, o_we, o_addr, o_wdata, o_be, we, addr, wd, be);
            end
         end else begin
            checks++;
            if (o_ready !== 1'b1 || o_sel !== '0) begin
               errors++;
               $display("FAIL %s resp c=%0d ready=%b sel=%b exp ready=1 sel=0",
                        tag, c, o_ready, o_sel);
            end
            checks++;
            if (o_err !== exp_err || o_rdata !== exp_rd) begin
               errors++;
               $display("FAIL %s resp_data err=%b rdata=%h exp err=%b rdata=%h",
                        tag, o_err, o_rdata, exp_err, exp_rd);
            end
         end
         // Drive inputs for this cycle. Master inputs are junk after the latch.
         junk_inputs();
         if (idx >= 0 && c < resp_cyc) begin
            s_ready[idx] = (c - 1 == delay);
            if (c - 1 == delay) exp_rd = we ? 32'h0 : s_rdata[idx*32 +: 32];
         end
      end
      @(posedge clk); #1;
      m_req = 1'b0;
      checks++;
      if (o_ready !== 1'b0 || o_sel !== '0 || o_err !== exp_err || o_rdata !== exp_rd) begin
         errors++;
         $display("FAIL %s hold ready=%b sel=%b err=%b rdata=%h exp 0/0/%b/%h",
                  tag, o_ready, o_sel, o_err, o_rdata, exp_err, exp_rd);
      end
   endtask

   task automatic test_reset();
      junk_inputs();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_req = 1'b0;
      checks++;
      if (o_sel !== '0 || o_ready !== 1'b0 || o_err !== 1'b0 || o_rdata !== '0) begin
         errors++;
         $display("FAIL reset_master sel=%b ready=%b err=%b rdata=%h exp all 0",
                  o_sel, o_ready, o_err, o_rdata);
      end
      checks++;
      if ({o_we, o_addr, o_wdata, o_be} !== 69'h0) begin
         errors++;
         $display("FAIL reset_slave got %b/%h/%h/%b exp all 0", o_we, o_addr, o_wdata, o_be);
      end
   endtask

   task automatic test_directed();
      do_xfer(32'h0000_0010, 1'b0, 32'h0, 4'hF, 0, "read_s0");
      do_xfer(32'h2000_0004, 1'b1, 32'h1234_5678, 4'b0011, 3, "write_s2");
      do_xfer(32'h5000_0000, 1'b0, 32'h0, 4'hF, 0, "miss");
      do_xfer(32'h3FFF_FFFC, 1'b0, 32'h0, 4'hF, 1, "read_s3_top");
   endtask

   task automatic test_timeout();
      if (TMO_EN) begin
         do_xfer(32'h1000_0000, 1'b0, 32'h0, 4'hF, 1000, "tmo_abort");
         do_xfer(32'h1000_0000, 1'b0, 32'h0, 4'hF, TMO - 1, "tmo_edge_ready");
      end else begin
         do_xfer(32'h1000_0000, 1'b0, 32'h0, 4'hF, 40, "long_wait");
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         int d;
         a = {4'($urandom_range(0, 7)), 28'($urandom)};
         d = $urandom_range(0, 5);
         if (TMO_EN && $urandom_range(0, 5) == 0) d = TMO - 2 + $urandom_range(0, 3);
         do_xfer(a, 1'($urandom), $urandom, 4'($urandom), d, "random");
      end
   endtask

   task automatic test_reset_mid_access();
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h3000_0040; m_wdata = 32'h0; m_be = 4'hF;
      s_ready = '0;
      @(posedge clk); #1;
      m_req = 1'b0;
      checks++;
      if (o_sel !== 4'b1000) begin
         errors++;
         $display("FAIL rst_mid_sel sel=%b exp 1000", o_sel);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      s_ready = '1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (o_sel !== '0 || o_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_abort sel=%b ready=%b exp 0/0", o_sel, o_ready);
      end
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         checks++;
         if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_ready c=%0d ready=%b exp 0", c, o_ready);
         end
      end
      do_xfer(32'h1000_0000, 1'b0, 32'h0, 4'hF, 0, "after_reset");
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 6; n++)
         do_xfer({4'($urandom_range(0, 3)), 28'($urandom)}, 1'($urandom),
                 $urandom, 4'($urandom), n % 3, "b2b");
   endtask

   task automatic test_overlap();
      use_ovl = 1'b1;
      do_xfer(32'h1000_0000, 1'b0, 32'h0, 4'hF, 0, "overlap_s0");
      do_xfer(32'h0000_0100, 1'b1, 32'hCAFE_F00D, 4'hF, 2, "overlap_low");
      use_ovl = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      junk_inputs();
      m_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_directed();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset();
      test_reset_mid_access();
      test_overlap();
      do_xfer(32'h7000_0000, 1'b0, 32'h0, 4'hF, 0, "miss_before_reset");
      test_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
